// File: rtl/soc_periph_subsys.sv
// rtl/soc_periph_subsys.sv - APB3 peripheral block: GPIO bank, prescaled 32-bit timer, IRQ aggregator.
// Zero-wait-state slave; all state in one clock domain, synchronous active-high reset.
module soc_periph_subsys #(
  parameter int          NumGpio   = 16,
  parameter int          AddrWidth = 12,
  parameter logic [31:0] IdValue   = 32'h50E1_0001
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [AddrWidth-1:0] paddr_i,
  input  logic [31:0]          pwdata_i,
  output logic [31:0]          prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  input  logic [NumGpio-1:0]   gpio_i,
  output logic [NumGpio-1:0]   gpio_o,
  output logic [NumGpio-1:0]   gpio_oe_o,
  output logic                 irq_o
);

  localparam int WW = AddrWidth - 2;
  localparam logic [WW-1:0] A_ID      = WW'(0);
  localparam logic [WW-1:0] A_OUT     = WW'(1);
  localparam logic [WW-1:0] A_OE      = WW'(2);
  localparam logic [WW-1:0] A_IN      = WW'(3);
  localparam logic [WW-1:0] A_CTRL    = WW'(4);
  localparam logic [WW-1:0] A_CNT     = WW'(5);
  localparam logic [WW-1:0] A_CMP     = WW'(6);
  localparam logic [WW-1:0] A_STATUS  = WW'(7);
  localparam logic [WW-1:0] A_IRQ_EN  = WW'(8);
  localparam logic [WW-1:0] A_RISE_EN = WW'(9);

  logic [NumGpio-1:0] r_gpio_out, r_gpio_oe, r_rise_en;
  logic [NumGpio-1:0] r_sync1, r_sync2, r_sync2_q;
  logic               r_tmr_en, r_tmr_ar;
  logic [7:0]         r_tmr_pre, r_pre_cnt;
  logic [31:0]        r_cnt, r_cmp;
  logic [1:0]         r_status, r_irq_en;
  logic               r_irq;

  logic [WW-1:0] w_word;
  logic          w_access, w_mapped, w_ro, w_we;
  logic          w_tick, w_cnt_wr, w_match_set, w_gpio_set;
  logic [1:0]    w_set, w_clr;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_word   = paddr_i[AddrWidth-1:2];
  assign w_access = psel_i & penable_i;
  assign w_mapped = (w_word <= A_RISE_EN);
  assign w_ro     = (w_word == A_ID) | (w_word == A_IN);
  assign w_we     = w_access & pwrite_i & w_mapped & ~w_ro;
  assign w_unused = ^paddr_i[1:0];

  assign pready_o  = 1'b1;
  assign pslverr_o = w_access & (~w_mapped | (pwrite_i & w_ro));
  assign prdata_o  = w_access ? w_rdata : 32'h0;

  always_comb begin
    w_rdata = 32'h0;
    case (w_word)
      A_ID:      w_rdata = IdValue;
      A_OUT:     w_rdata = 32'(r_gpio_out);
      A_OE:      w_rdata = 32'(r_gpio_oe);
      A_IN:      w_rdata = 32'(r_sync2);
      A_CTRL:    w_rdata = {16'h0, r_tmr_pre, 6'h0, r_tmr_ar, r_tmr_en};
      A_CNT:     w_rdata = r_cnt;
      A_CMP:     w_rdata = r_cmp;
      A_STATUS:  w_rdata = {30'h0, r_status};
      A_IRQ_EN:  w_rdata = {30'h0, r_irq_en};
      A_RISE_EN: w_rdata = 32'(r_rise_en);
      default:   w_rdata = 32'h0;
    endcase
  end

  // A software CNT write swallows a coincident tick, including its match.
  assign w_tick      = r_tmr_en & (r_pre_cnt == r_tmr_pre);
  assign w_cnt_wr    = w_we & (w_word == A_CNT);
  assign w_match_set = w_tick & ~w_cnt_wr & (r_cnt == r_cmp);
  assign w_gpio_set  = |(r_sync2 & ~r_sync2_q & r_rise_en);
  assign w_set       = {w_gpio_set, w_match_set};
  assign w_clr       = (w_we && w_word == A_STATUS) ? pwdata_i[1:0] : 2'b00;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gpio_out <= '0;
      r_gpio_oe  <= '0;
      r_rise_en  <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_sync2_q  <= '0;
      r_tmr_en   <= 1'b0;
      r_tmr_ar   <= 1'b0;
      r_tmr_pre  <= 8'h0;
      r_pre_cnt  <= 8'h0;
      r_cnt      <= 32'h0;
      r_cmp      <= 32'h0;
      r_status   <= 2'b00;
      r_irq_en   <= 2'b00;
      r_irq      <= 1'b0;
    end else begin
      r_sync1   <= gpio_i;
      r_sync2   <= r_sync1;
      r_sync2_q <= r_sync2;

      if (w_we && w_word == A_OUT)     r_gpio_out <= pwdata_i[NumGpio-1:0];
      if (w_we && w_word == A_OE)      r_gpio_oe  <= pwdata_i[NumGpio-1:0];
      if (w_we && w_word == A_RISE_EN) r_rise_en  <= pwdata_i[NumGpio-1:0];
      if (w_we && w_word == A_IRQ_EN)  r_irq_en   <= pwdata_i[1:0];
      if (w_we && w_word == A_CMP)     r_cmp      <= pwdata_i;
      if (w_we && w_word == A_CTRL) begin
        r_tmr_en  <= pwdata_i[0];
        r_tmr_ar  <= pwdata_i[1];
        r_tmr_pre <= pwdata_i[15:8];
      end

      if (!r_tmr_en || w_tick) r_pre_cnt <= 8'h0;
      else                     r_pre_cnt <= r_pre_cnt + 8'h1;

      if (w_cnt_wr)                     r_cnt <= pwdata_i;
      else if (w_match_set && r_tmr_ar) r_cnt <= 32'h0;
      else if (w_tick)                  r_cnt <= r_cnt + 32'h1;

      r_status <= (r_status & ~w_clr) | w_set;
      r_irq    <= |(r_status & r_irq_en);
    end
  end

  assign gpio_o    = r_gpio_out;
  assign gpio_oe_o = r_gpio_oe;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_soc_periph_subsys.sv
// tb/tb_soc_periph_subsys.sv - randomized self-checking bench with an arithmetic timer/GPIO model.
module tb_soc_periph_subsys;

  logic        clk, rst, psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, irq;
  logic [15:0] gpio_i, gpio_o, gpio_oe;
  int          n_checks, n_err, cyc;

  soc_periph_subsys dut (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
    .pslverr_o(pslverr), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe_o(gpio_oe), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  // Timer as a sequence of ticks: one tick every p+1 enabled cycles, applied rule by rule.
  function automatic void model_timer(input logic [31:0] s, input logic [31:0] cmp, input bit ar,
                                      input int p, input int k,
                                      output logic [31:0] cnt, output bit st);
    int ticks;
    ticks = k / (p + 1);
    cnt = s;
    st = 1'b0;
    for (int i = 0; i < ticks; i++) begin
      if (cnt == cmp) begin
        st = 1'b1;
        cnt = ar ? 32'h0 : cnt + 32'h1;
      end else begin
        cnt = cnt + 32'h1;
      end
    end
  endfunction

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err, output int t);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    #1 err = pslverr;
    @(posedge clk);
    #1;
    t = cyc;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err, output int t);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1;
    d = prdata; err = pslverr; t = cyc;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e;
    int t;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (gpio_o !== 16'h0 || gpio_oe !== 16'h0 || irq !== 1'b0 || pready !== 1'b1 || prdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got gpio_o=%h oe=%h irq=%b pready=%b prdata=%h, want 0 0 0 1 0",
               gpio_o, gpio_oe, irq, pready, prdata);
    end
    apb_read(12'h000, d, e, t);
    n_checks++;
    if (d !== 32'h50E1_0001 || e !== 1'b0) begin
      n_err++;
      $display("FAIL reset_id: got %h err=%b, want 50e10001 err=0", d, e);
    end
    for (int a = 4; a <= 36; a += 4) begin
      apb_read(12'(a), d, e, t);
      n_checks++;
      if (d !== 32'h0 || e !== 1'b0) begin
        n_err++;
        $display("FAIL reset_reg_%0h: got %h err=%b, want 0 err=0", a, d, e);
      end
    end
  endtask

  task automatic test_gpio();
    logic [31:0] d, v, w, g;
    logic e;
    int t;
    for (int i = 0; i < 6; i++) begin
      v = (i == 0) ? 32'h0000_A5A5 : $urandom;
      w = (i == 0) ? 32'h0000_FFFF : $urandom;
      apb_write(12'h004, v, e, t);
      apb_write(12'h008, w, e, t);
      n_checks++;
      if (gpio_o !== v[15:0] || gpio_oe !== w[15:0]) begin
        n_err++;
        $display("FAIL gpio_pins_%0d: got out=%h oe=%h, want %h %h", i, gpio_o, gpio_oe, v[15:0], w[15:0]);
      end
      apb_read(12'h004, d, e, t);
      n_checks++;
      if (d !== {16'h0, v[15:0]}) begin
        n_err++;
        $display("FAIL gpio_out_readback_%0d: got %h, want %h", i, d, {16'h0, v[15:0]});
      end
      g = $urandom;
      gpio_i = g[15:0];
      repeat (3) @(posedge clk);
      apb_read(12'h00C, d, e, t);
      n_checks++;
      if (d !== {16'h0, g[15:0]}) begin
        n_err++;
        $display("FAIL gpio_in_%0d: got %h, want %h", i, d, {16'h0, g[15:0]});
      end
    end
    apb_write(12'h00C, 32'h1234, e, t);
    apb_read(12'h00C, d, e, t);
    n_checks++;
    if (d !== {16'h0, gpio_i}) begin
      n_err++;
      $display("FAIL gpio_in_ro_write: got %h, want %h", d, {16'h0, gpio_i});
    end
    apb_write(12'h00C, 32'h1234, e, t);
    n_checks++;
    if (e !== 1'b1) begin
      n_err++;
      $display("FAIL ro_write_err: got pslverr=%b, want 1", e);
    end
    apb_read(12'h040, d, e, t);
    n_checks++;
    if (d !== 32'h0 || e !== 1'b1) begin
      n_err++;
      $display("FAIL unmapped_read: got %h err=%b, want 0 err=1", d, e);
    end
  endtask

  task automatic test_gpio_irq();
    logic [31:0] d;
    logic e;
    int t;
    gpio_i = 16'h0;
    repeat (4) @(posedge clk);
    apb_write(12'h024, 32'h8, e, t);
    apb_write(12'h020, 32'h2, e, t);
    apb_write(12'h01C, 32'h3, e, t);
    gpio_i[3] = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1;
    n_checks++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_early: got %b, want 0", irq);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_gpio_rise: got %b, want 1", irq);
    end
    apb_read(12'h01C, d, e, t);
    n_checks++;
    if (d !== 32'h2) begin
      n_err++;
      $display("FAIL status_gpio: got %h, want 2", d);
    end
    apb_write(12'h01C, 32'h2, e, t);
    @(posedge clk);
    #1;
    n_checks++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_after_w1c: got %b, want 0", irq);
    end
  endtask

  task automatic test_timer_random();
    logic [31:0] d, ecnt, s, cmp;
    logic e;
    bit ar, est;
    int t0, t, p;
    for (int it = 0; it < 8; it++) begin
      p   = (it == 0) ? 1 : int'($urandom_range(0, 3));
      cmp = (it == 0) ? 32'd3 : 32'($urandom_range(2, 6));
      ar  = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      s   = (it == 0) ? 32'd0 : 32'($urandom_range(0, 2));
      apb_write(12'h010, 32'h0, e, t);
      apb_write(12'h01C, 32'h1, e, t);
      apb_write(12'h018, cmp, e, t);
      apb_write(12'h014, s, e, t);
      apb_write(12'h010, {16'h0, 8'(p), 6'h0, ar, 1'b1}, e, t0);
      for (int r = 0; r < 4; r++) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        apb_read(12'h014, d, e, t);
        model_timer(s, cmp, ar, p, t - t0, ecnt, est);
        n_checks++;
        if (d !== ecnt) begin
          n_err++;
          $display("FAIL timer_cnt it%0d p=%0d cmp=%0d ar=%0d k=%0d: got %0d, want %0d",
                   it, p, cmp, ar, t - t0, d, ecnt);
        end
        apb_read(12'h01C, d, e, t);
        model_timer(s, cmp, ar, p, t - t0, ecnt, est);
        n_checks++;
        if (d[0] !== est) begin
          n_err++;
          $display("FAIL timer_status it%0d k=%0d: got %b, want %b", it, t - t0, d[0], est);
        end
      end
    end
  endtask

  task automatic test_timer_wrap();
    logic [31:0] d, ecnt;
    logic e;
    bit est;
    int t0, t;
    apb_write(12'h010, 32'h0, e, t);
    apb_write(12'h01C, 32'h1, e, t);
    apb_write(12'h018, 32'd5, e, t);
    apb_write(12'h014, 32'hFFFF_FFFF, e, t);
    apb_write(12'h010, 32'h1, e, t0);
    apb_read(12'h014, d, e, t);
    model_timer(32'hFFFF_FFFF, 32'd5, 1'b0, 0, t - t0, ecnt, est);
    n_checks++;
    if (d !== ecnt) begin
      n_err++;
      $display("FAIL timer_wrap: got %h, want %h", d, ecnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, ecnt;
    logic e;
    bit est;
    int t0, t;
    apb_write(12'h010, 32'h0, e, t);
    apb_write(12'h01C, 32'h1, e, t);
    apb_write(12'h018, 32'd3, e, t);
    apb_write(12'h014, 32'h0, e, t);
    apb_write(12'h010, 32'h1, e, t0);
    @(posedge clk); @(posedge clk);
    apb_write(12'h01C, 32'h1, e, t);
    n_checks++;
    if (t - t0 != 4) begin
      n_err++;
      $display("FAIL w1c_alignment: got edge offset %0d, want 4", t - t0);
    end
    apb_read(12'h01C, d, e, t);
    n_checks++;
    if (d[0] !== 1'b1) begin
      n_err++;
      $display("FAIL set_beats_w1c: got %b, want 1", d[0]);
    end
    apb_write(12'h014, 32'h10, e, t0);
    apb_read(12'h014, d, e, t);
    model_timer(32'h10, 32'd3, 1'b0, 0, t - t0, ecnt, est);
    n_checks++;
    if (d !== ecnt) begin
      n_err++;
      $display("FAIL cnt_write_on_tick: got %h, want %h", d, ecnt);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d;
    logic e;
    int t;
    @(negedge clk);
    rst = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'hFFFF;
    @(posedge clk);
    #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    n_checks++;
    if (gpio_o !== 16'h0 || gpio_oe !== 16'h0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL midop_reset_pins: got out=%h oe=%h irq=%b, want 0 0 0", gpio_o, gpio_oe, irq);
    end
    apb_read(12'h010, d, e, t);
    n_checks++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL midop_reset_ctrl: got %h, want 0", d);
    end
    apb_read(12'h014, d, e, t);
    n_checks++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL midop_reset_cnt: got %h, want 0", d);
    end
    apb_read(12'h01C, d, e, t);
    n_checks++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL midop_reset_status: got %h, want 0", d);
    end
  endtask

  initial begin
    n_checks = 0; n_err = 0; cyc = 0;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h0; pwdata = 32'h0; gpio_i = 16'h0;
    test_reset();
    test_gpio();
    test_gpio_irq();
    test_timer_random();
    test_timer_wrap();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
